// File: rtl/mem_port_arbiter.sv
// Two-requester cache-line port arbiter: serialises one line at a time into word transactions.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority to requester 0.
module mem_port_arbiter #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     r0_req_valid,
  input  logic                     r0_req_store,
  input  logic [31:0]              r0_req_addr,
  input  logic [LINE_WORDS*32-1:0] r0_req_wdata,
  output logic                     r0_req_ready,
  output logic                     r0_rsp_valid,
  output logic [LINE_WORDS*32-1:0] r0_rsp_rdata,

  input  logic                     r1_req_valid,
  input  logic                     r1_req_store,
  input  logic [31:0]              r1_req_addr,
  input  logic [LINE_WORDS*32-1:0] r1_req_wdata,
  output logic                     r1_req_ready,
  output logic                     r1_rsp_valid,
  output logic [LINE_WORDS*32-1:0] r1_rsp_rdata,

  output logic                     mem_valid,
  output logic                     mem_store,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_done,

  output logic                     busy
);

  localparam int unsigned CW  = $clog2(LINE_WORDS);
  localparam int unsigned OFF = CW + 2;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            next_cnt;
  logic                     gnt;
  logic                     lat_store;
  logic [31:OFF]            lat_line;
  logic [31:0]              line_q [LINE_WORDS];
  logic [LINE_WORDS*32-1:0] line_flat;

  logic                     idle;
  logic                     win1;
  logic                     hs;
  logic                     sel_store;
  logic [31:OFF]            sel_line;
  logic [LINE_WORDS*32-1:0] sel_wdata;
  logic                     addr_lsb_unused;

`ifdef ARB_ROUND_ROBIN_EN
  logic                     last_grant;
`endif

  // Byte/word offset bits of the request address carry no information for a line request.
  assign addr_lsb_unused = ^{r0_req_addr[OFF-1:0], r1_req_addr[OFF-1:0]};

  always_comb begin
    idle = (state == IDLE) && rst_n;
`ifdef ARB_ROUND_ROBIN_EN
    win1 = r1_req_valid && (!r0_req_valid || !last_grant);
`else
    win1 = r1_req_valid && !r0_req_valid;
`endif
    r1_req_ready = idle && win1;
    r0_req_ready = idle && r0_req_valid && !win1;
    hs           = r0_req_ready || r1_req_ready;
    sel_store    = win1 ? r1_req_store        : r0_req_store;
    sel_line     = win1 ? r1_req_addr[31:OFF] : r0_req_addr[31:OFF];
    sel_wdata    = win1 ? r1_req_wdata        : r0_req_wdata;
    next_cnt     = cnt + 1'b1;
  end

  always_comb begin
    line_flat = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      line_flat[32*i +: 32] = line_q[i];
    end
  end

  assign r0_rsp_rdata = line_flat;
  assign r1_rsp_rdata = line_flat;
  assign busy         = (state != IDLE);

  // The line buffer holds the writeback line on stores and collects refill words on loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= 1'b0;
      lat_store    <= 1'b0;
      lat_line     <= '0;
      mem_valid    <= 1'b0;
      mem_store    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant   <= 1'b1;
`endif
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            gnt       <= win1;
            lat_store <= sel_store;
            lat_line  <= sel_line;
            cnt       <= '0;
            mem_valid <= 1'b1;
            mem_store <= sel_store;
            mem_addr  <= {sel_line, {CW{1'b0}}, 2'b00};
            mem_wdata <= sel_wdata[31:0];
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= win1;
`endif
            if (sel_store) begin
              for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= sel_wdata[32*i +: 32];
              end
            end
            state <= XFER;
          end
        end
        XFER: begin
          if (mem_done) begin
            if (!lat_store) begin
              line_q[cnt] <= mem_rdata;
            end
            if (cnt == CW'(LINE_WORDS - 1)) begin
              mem_valid    <= 1'b0;
              mem_store    <= 1'b0;
              r0_rsp_valid <= !gnt;
              r1_rsp_valid <= gnt;
              state        <= RESP;
            end else begin
              cnt       <= next_cnt;
              mem_addr  <= {lat_line, next_cnt, 2'b00};
              mem_wdata <= line_q[next_cnt];
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver pushes expected word transactions and line
// responses on each handshake; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned LW = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req_valid, r0_req_store, r0_req_ready, r0_rsp_valid;
  logic [31:0]   r0_req_addr;
  logic [255:0]  r0_req_wdata, r0_rsp_rdata;
  logic          r1_req_valid, r1_req_store, r1_req_ready, r1_rsp_valid;
  logic [31:0]   r1_req_addr;
  logic [255:0]  r1_req_wdata, r1_rsp_rdata;
  logic          mem_valid, mem_store, mem_done, busy;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [31:0]   salt;

  always #5 clk = ~clk;
  assign mem_rdata = mem_addr ^ salt;

  mem_port_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_store(r0_req_store), .r0_req_addr(r0_req_addr),
    .r0_req_wdata(r0_req_wdata), .r0_req_ready(r0_req_ready), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_rdata(r0_rsp_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_store(r1_req_store), .r1_req_addr(r1_req_addr),
    .r1_req_wdata(r1_req_wdata), .r1_req_ready(r1_req_ready), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_rdata(r1_rsp_rdata),
    .mem_valid(mem_valid), .mem_store(mem_store), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
  );

  typedef struct { logic [31:0] addr; logic store; logic [31:0] wdata; } mem_t;
  typedef struct { int who; logic store; logic [255:0] rdata; int acc; } rsp_t;

  mem_t         memq[$];
  rsp_t         rspq[$];
  int           gnt_log[$];
  int           n_chk = 0, n_fail = 0;
  int           cyc = 0;
  int           lg_m = 1;
  int           rsp_cyc = -1;
  int           done_mode = 0;
  int           prob = 0;
  bit           rand_on = 1'b0;
  bit           keep[2], iss[2], hs_prev[2];
  logic         iss_store[2];
  logic [31:0]  iss_addr[2];
  logic [255:0] iss_wdata[2];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit model_idle();
    return memq.size() == 0 && rspq.size() == 0 && rsp_cyc != cyc;
  endfunction

  task automatic drive(input int n, input logic st, input logic [31:0] a, input logic [255:0] w);
    if (n == 0) begin
      r0_req_valid = 1'b1; r0_req_store = st; r0_req_addr = a; r0_req_wdata = w;
    end else begin
      r1_req_valid = 1'b1; r1_req_store = st; r1_req_addr = a; r1_req_wdata = w;
    end
  endtask

  task automatic issue(input int n, input logic st, input logic [31:0] a, input logic [255:0] w);
    iss[n] = 1'b1; iss_store[n] = st; iss_addr[n] = a; iss_wdata[n] = w;
  endtask

  // Reference: a line request becomes LW ascending word transactions and one response.
  task automatic accept(input int w, input bit both);
    logic st; logic [31:0] a, base, wa; logic [255:0] wd, rd;
    mem_t m; rsp_t r;
    if (both) chk("grant_choice", w, RR ? (lg_m == 1 ? 0 : 1) : 0);
    lg_m = w;
    gnt_log.push_back(w);
    hs_prev[w] = 1'b1;
    st = w ? r1_req_store : r0_req_store;
    a  = w ? r1_req_addr  : r0_req_addr;
    wd = w ? r1_req_wdata : r0_req_wdata;
    base = {a[31:5], 5'b0};
    for (int k = 0; k < LW; k++) begin
      wa = base + 32'(4 * k);
      m.addr = wa; m.store = st; m.wdata = wd[32*k +: 32];
      memq.push_back(m);
      rd[32*k +: 32] = wa ^ salt;
    end
    r.who = w; r.store = st; r.rdata = rd; r.acc = cyc;
    rspq.push_back(r);
  endtask

  task automatic cycle();
    logic v0, v1, h0, h1;
    @(negedge clk);
    if (hs_prev[0]) r0_req_valid = 1'b0;
    if (hs_prev[1]) r1_req_valid = 1'b0;
    hs_prev[0] = 1'b0; hs_prev[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (!(n ? r1_req_valid : r0_req_valid)) begin
        if (iss[n]) begin
          drive(n, iss_store[n], iss_addr[n], iss_wdata[n]);
          iss[n] = 1'b0;
        end else if (keep[n] || (rand_on && $urandom_range(99) < prob)) begin
          drive(n, 1'($urandom_range(1)), $urandom, rand_line());
        end
      end
    end
    case (done_mode)
      0:       mem_done = 1'b1;
      1:       mem_done = (cyc % 3 == 0);
      default: mem_done = 1'($urandom_range(1));
    endcase
    #3;
    v0 = r0_req_valid; v1 = r1_req_valid;
    h0 = v0 && r0_req_ready; h1 = v1 && r1_req_ready;
    chk("ready_without_valid", {r0_req_ready && !v0, r1_req_ready && !v1}, 2'b00);
    if (model_idle()) begin
      if (v0 || v1) chk("accept_when_idle", h0 || h1, 1'b1);
    end else begin
      chk("ready_while_busy", r0_req_ready || r1_req_ready, 1'b0);
    end
    if (h0 || h1) begin
      chk("single_winner", h0 && h1, 1'b0);
      accept(h1 ? 1 : 0, v0 && v1);
    end
  endtask

  function automatic bit quiet();
    return model_idle() && !r0_req_valid && !r1_req_valid && !iss[0] && !iss[1];
  endfunction

  task automatic drain(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (quiet()) break;
      cycle();
    end
    if (!quiet()) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: actual busy after %0d cycles required idle", lim);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 1'b0);
    chk({tag, "_mem_store"}, mem_store, 1'b0);
    chk({tag, "_mem_addr"},  mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_busy"},      busy, 1'b0);
    chk({tag, "_ready"},     {r0_req_ready, r1_req_ready}, 2'b00);
    chk({tag, "_rsp_valid"}, {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    chk({tag, "_rsp_rdata"}, r0_rsp_rdata | r1_rsp_rdata, 256'h0);
  endtask

  task automatic monitor_step();
    mem_t m; rsp_t r;
    chk("busy", busy, memq.size() != 0 || rspq.size() != 0);
    chk("mem_valid", mem_valid, memq.size() != 0);
    if (mem_valid && memq.size() != 0) begin
      m = memq[0];
      chk("mem_addr", mem_addr, m.addr);
      chk("mem_store", mem_store, m.store);
      if (m.store) chk("mem_wdata", mem_wdata, m.wdata);
      if (mem_done) void'(memq.pop_front());
    end
    for (int n = 0; n < 2; n++) begin
      if (n ? r1_rsp_valid : r0_rsp_valid) begin
        if (rspq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp_unexpected: actual r%0d_rsp_valid=1 required 0 (cycle %0d)", n, cyc);
        end else begin
          r = rspq.pop_front();
          rsp_cyc = cyc;
          chk("rsp_who", n, r.who);
          if (!r.store) chk("rsp_rdata", n ? r1_rsp_rdata : r0_rsp_rdata, r.rdata);
          if (done_mode == 0) chk("rsp_latency", cyc - r.acc, 9);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) monitor_step();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nexp;
    int exp_seq[4];
    logic [255:0] wd;
    rst_n = 1'b0; mem_done = 1'b0; salt = '0;
    r0_req_valid = 1'b0; r0_req_store = 1'b0; r0_req_addr = '0; r0_req_wdata = '0;
    r1_req_valid = 1'b0; r1_req_store = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    keep[0] = 0; keep[1] = 0; iss[0] = 0; iss[1] = 0; hs_prev[0] = 0; hs_prev[1] = 0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    // Directed load with memory always ready and rdata equal to the word address.
    done_mode = 0;
    issue(0, 1'b0, 32'h0000_1040, '0);
    drain(60);

    // Directed store, memory completing every third cycle.
    done_mode = 1;
    for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'hA0 + 32'(k);
    issue(1, 1'b1, 32'h0000_2000, wd);
    drain(120);

    // Both requesters keep requesting back-to-back.
    done_mode = 0;
    gnt_log.delete();
    nexp = RR ? 4 : 3;
    exp_seq = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    keep[0] = 1; keep[1] = 1;
    for (int i = 0; i < 100 && gnt_log.size() < nexp; i++) cycle();
    keep[0] = 0; keep[1] = 0;
    chk("grant_count", gnt_log.size() >= nexp, 1'b1);
    for (int i = 0; i < nexp && i < gnt_log.size(); i++) chk("grant_seq", gnt_log[i], exp_seq[i]);
    drain(100);

    // Reset in the middle of a load: abandoned, nothing responds, fresh request restarts at word 0.
    done_mode = 0;
    issue(0, 1'b0, $urandom, '0);
    for (int i = 0; i < 30 && memq.size() != 5; i++) cycle();
    chk("mid_load_words_left", memq.size(), 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    memq.delete(); rspq.delete();
    lg_m = 1; hs_prev[0] = 0; hs_prev[1] = 0;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    salt = 32'h5A5A_0F0F;
    issue(0, 1'b0, 32'h0000_3000, '0);
    drain(60);

    // Randomised traffic with a random memory completion pattern.
    salt = $urandom;
    done_mode = 2;
    prob = 30;
    rand_on = 1'b1;
    repeat (2500) cycle();
    rand_on = 1'b0;
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per cache line (256-bit line).
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rN_req_valid  input  1  requester N (N=0,1) line request pending.
REQ-005 SHALL have ports rN_req_store  input  1  0 = line refill (load), 1 = line writeback (store).
REQ-006 SHALL have ports rN_req_addr  input  32  line address; bits [4:0] ignored.
REQ-007 SHALL have ports rN_req_wdata  input  256  writeback line; word k = bits [32k+31:32k].
REQ-008 SHALL have ports rN_req_ready  output  1  request accepted this cycle.
REQ-009 SHALL have ports rN_rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports rN_rsp_rdata  output  256  refilled line, valid with rN_rsp_valid on loads.
REQ-011 SHALL have port mem_valid  output  1  word transaction pending to memory.
REQ-012 SHALL have port mem_store  output  1  0 = read word, 1 = write word.
REQ-013 SHALL have port mem_addr  output  32  word address.
REQ-014 SHALL have port mem_wdata  output  32  write word.
REQ-015 SHALL have port mem_rdata  input  32  read word, sampled when mem_done=1.
REQ-016 SHALL have port mem_done  input  1  memory completed the current word.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, XFER, RESP.
REQ-019 IDLE: if any rN_req_valid, SHALL assert rN_req_ready (combinational) for exactly one winner; handshake = valid && ready; winner's store/addr/wdata latched; next state XFER, word counter = 0.
REQ-020 Requesters SHALL hold req fields stable until ready; losing requester sees ready=0 and keeps waiting.
REQ-021 XFER: mem_valid=1, mem_store=latched store, mem_addr={addr[31:5], cnt[2:0], 2'b00}, mem_wdata=latched word cnt, all stable until mem_done.
REQ-022 XFER on mem_done: load SHALL write mem_rdata into line buffer word cnt; if cnt==LINE_WORDS-1 go RESP, else cnt+1 and remain in XFER.
REQ-023 Words SHALL be transferred in ascending order 0..7, one memory transaction at a time.
REQ-024 RESP: rN_rsp_valid=1 for granted N for exactly one cycle, rN_rsp_rdata=line buffer; next state IDLE; no request accepted in RESP.
REQ-025 Latency with mem_done tied high: accept cycle 0, words cycles 1..8, rsp_valid cycle 9, next accept cycle 10.
REQ-026 mem_done outside XFER SHALL be ignored; rN_rsp_rdata on stores SHALL be don't-care.
REQ-027 Non-granted rsp_valid, all req_ready outside IDLE, and mem_valid outside XFER SHALL be 0.

Reset
REQ-028 On rst_n=0 (any state, including mid-XFER) SHALL enter IDLE; cnt=0; line buffer=0; all outputs 0; last_grant=1; abandoned transfer is not resumed or responded to.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: when both request in IDLE, the requester not equal to last_grant wins; last_grant updated on each handshake.
REQ-030 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins when both request; last_grant unused.

Verification
REQ-031 r0 load addr 0x0000_1040, mem_done=1 always, mem_rdata=word addr -> mem_addr 0x1040..0x105C, r0_rsp_valid cycle 9, rdata word k=0x1040+4k.
REQ-032 r1 store addr 0x0000_2000, wdata words 0xA0..0xA7, mem_done every 3rd cycle -> 8 mem writes to 0x2000..0x201C with 0xA0..0xA7, inputs held stable between dones, r1_rsp_valid one cycle.
REQ-033 r0 and r1 request simultaneously, twice back-to-back -> with ARB_ROUND_ROBIN_EN grants r0,r1,r0,r1; without it r0,r0,r0 while r0 keeps requesting.
REQ-034 rst_n asserted after 3 words of a load -> outputs 0 next edge, busy=0, no rsp_valid; fresh request afterwards starts at word 0.
REQ-035 mem_done pulsed in IDLE and RESP -> no counter change, no extra mem transaction.
